// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared definitions for the ALU sharing controller.
//   - WIDTH_DEF / OPW_DEF : default operand and opcode widths
//   - state_t             : controller FSM states
//   - owner_t             : requester id (one bit, two requesters)
//   - owner_onehot()      : maps an owner id to a per-port one-hot vector
package alu_share_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int OPW_DEF   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic owner_t;

    function automatic logic [1:0] owner_onehot(input owner_t id);
        logic [1:0] vec;
        if (id == 1'b1) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/alu.sv
// ALU: shared 64-bit combinational arithmetic/logic unit.
//   a, b : operands
//   cont : operation select (00 AND, 01 OR, 10 ADD, 11 SUB a-b)
//   out  : result, same width as the operands (carry/borrow dropped)
module ALU #(
    parameter int WIDTH = 64,
    parameter int OPW   = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   cont,
    output logic [WIDTH-1:0] out
);

    // Operation decode.
    always_comb begin
        out = '0;
        case (cont)
            2'b00:   out = a & b;
            2'b01:   out = a | b;
            2'b10:   out = a + b;
            2'b11:   out = a - b;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_rr_arb2.sv
// rr_arb2: two-request round-robin picker.
//   req[1:0] : request vector
//   last     : most recently granted port
//   en       : grants are only produced while enabled
//   gnt[1:0] : one-hot grant (00 when disabled or nothing requested)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    // Grant selection: a lone request wins, a tie goes to the port that did not win last.
    always_comb begin
        gnt = 2'b00;
        if (en == 1'b1) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last == 1'b1) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end else begin
            gnt = 2'b00;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-port request handshake (operands req_a*/req_b*, opcode req_op*)
//   rsp_valid/rsp_ready   : per-port response handshake, data on shared rsp_data
//   busy                  : high whenever a transaction is in flight
// One transaction at a time: IDLE (accept) -> EXEC (ALU evaluates latched operands)
// -> RESP (result held until the owning port accepts it).
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [OPW-1:0]   req_op0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [OPW-1:0]   req_op1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_t           state_r;
    state_t           next_state_s;
    logic             last_r;
    owner_t           owner_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [OPW-1:0]   op_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] alu_out_s;
    logic [1:0]       gnt_s;
    logic             arb_en_s;
    logic             accept_s;
    owner_t           gnt_id_s;
    logic [1:0]       rsp_valid_r;
    logic             busy_r;

    assign arb_en_s = (state_r == IDLE);
    assign gnt_id_s = gnt_s[1];

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (last_r),
        .en   (arb_en_s),
        .gnt  (gnt_s)
    );

    ALU #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .a    (a_r),
        .b    (b_r),
        .cont (op_r),
        .out  (alu_out_s)
    );

    // Next-state and request-ready decode; grants only exist for valid ports, so any grant is a handshake.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        req_ready    = 2'b00;
        case (state_r)
            IDLE: begin
                req_ready = gnt_s;
                if (gnt_s != 2'b00) begin
                    accept_s     = 1'b1;
                    next_state_s = EXEC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            EXEC: begin
                next_state_s = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_r] == 1'b1) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Arbitration pointer, owner id and operand capture on an accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r  <= 1'b1;
            owner_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            op_r    <= '0;
        end else if (accept_s) begin
            last_r  <= gnt_id_s;
            owner_r <= gnt_id_s;
            if (gnt_id_s == 1'b1) begin
                a_r  <= req_a1;
                b_r  <= req_b1;
                op_r <= req_op1;
            end else begin
                a_r  <= req_a0;
                b_r  <= req_b0;
                op_r <= req_op0;
            end
        end
    end

    // Result register: captures the ALU output at the end of EXEC and holds it through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= '0;
        end else if (state_r == EXEC) begin
            result_r <= alu_out_s;
        end
    end

    // Response valid and busy are registered from the next state so nothing leaks from inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 2'b00;
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (next_state_s != IDLE);
            if (next_state_s == RESP) begin
                rsp_valid_r <= owner_onehot(owner_r);
            end else begin
                rsp_valid_r <= 2'b00;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = result_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_op0, req_op1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_data;
    logic        busy;

    int n_tests;
    int n_fail;

    alu_share_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_op0   (req_op0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_op1   (req_op1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [63:0] a0;
        logic [63:0] b0;
        logic [1:0]  op0;
        logic [63:0] a1;
        logic [63:0] b1;
        logic [1:0]  op1;
        logic        exp_port;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] port_vec(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    // Starts and ends just after a negedge with the DUT in IDLE.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag       = $sformatf("vec%0d", idx);
        req_valid = v.valid;
        req_a0    = v.a0;  req_b0 = v.b0;  req_op0 = v.op0;
        req_a1    = v.a1;  req_b1 = v.b1;  req_op1 = v.op1;
        rsp_ready = 2'b11;
        #1;
        chk({tag, " req_ready"}, req_ready, port_vec(v.exp_port));
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        chk({tag, " exec busy"}, busy, 1'b1);
        chk({tag, " exec rsp_valid"}, rsp_valid, 2'b00);
        @(negedge clk);
        chk({tag, " rsp_valid"}, rsp_valid, port_vec(v.exp_port));
        chk({tag, " rsp_data"}, rsp_data, v.exp_data);
        @(negedge clk);
        chk({tag, " idle busy"}, busy, 1'b0);
        chk({tag, " idle rsp_valid"}, rsp_valid, 2'b00);
    endtask

    initial begin
        logic [63:0] b2b_a[3];
        logic [63:0] b2b_b[3];
        logic [1:0]  b2b_op[3];
        logic [63:0] b2b_exp[3];

        n_tests = 0;
        n_fail  = 0;

        // ALU: 00 AND, 01 OR, 10 ADD, 11 SUB. Rows 0-3 are ties straight out of reset.
        vecs[0] = '{2'b11, 64'd50, 64'd20, 2'b11, 64'd7, 64'd9, 2'b10, 1'b0, 64'd30};
        vecs[1] = '{2'b11, 64'd50, 64'd20, 2'b11, 64'd7, 64'd9, 2'b10, 1'b1, 64'd16};
        vecs[2] = '{2'b11, 64'hF0F0, 64'hFF00, 2'b00, 64'hF0, 64'h0F, 2'b01, 1'b0, 64'hF000};
        vecs[3] = '{2'b11, 64'hF0F0, 64'hFF00, 2'b00, 64'hF0, 64'h0F, 2'b01, 1'b1, 64'hFF};
        vecs[4] = '{2'b01, 64'd0, 64'd1, 2'b11, 64'd99, 64'd98, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{2'b11, 64'd11, 64'd12, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b10, 1'b1, 64'd0};
        vecs[6] = '{2'b10, 64'd1, 64'd1, 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10, 1'b1, 64'd0};
        vecs[7] = '{2'b10, 64'd1, 64'd1, 2'b10, 64'd3, 64'd5, 2'b00, 1'b1, 64'd1};
        vecs[8] = '{2'b01, 64'h1234, 64'h00FF, 2'b01, 64'd4, 64'd4, 2'b11, 1'b0, 64'h12FF};
        vecs[9] = '{2'b01, 64'hA5A5_0000_0000_005A, 64'h5A5A_0000_0000_00A5, 2'b01, 64'd4, 64'd4, 2'b11,
                    1'b0, 64'hFFFF_0000_0000_00FF};

        b2b_a   = '{64'd10, 64'hAA, 64'd1};
        b2b_b   = '{64'd3, 64'h0F, 64'd2};
        b2b_op  = '{2'b11, 2'b00, 2'b10};
        b2b_exp = '{64'd7, 64'h0A, 64'd3};

        rst = 1'b1;
        req_valid = 2'b00;
        req_a0 = '0; req_b0 = '0; req_op0 = 2'b00;
        req_a1 = '0; req_b1 = '0; req_op1 = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset busy", busy, 1'b0);
        chk("reset rsp_valid", rsp_valid, 2'b00);
        chk("reset rsp_data", rsp_data, 64'd0);
        chk("reset req_ready", req_ready, 2'b00);
        @(negedge clk);

        // Table: tie order from reset, then single-request and width corner cases.
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-pressure on a port-1 response, with non-owner rsp_ready asserted.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b10;
        req_a1 = 64'd100; req_b1 = 64'd1; req_op1 = 2'b10;
        rsp_ready = 2'b00;
        #1;
        chk("bp accept", req_ready, 2'b10);
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        @(negedge clk);
        @(negedge clk);
        rsp_ready = 2'b01;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d rsp_valid", k), rsp_valid, 2'b10);
            chk($sformatf("bp%0d rsp_data", k), rsp_data, 64'd101);
            chk($sformatf("bp%0d req_ready", k), req_ready, 2'b00);
            chk($sformatf("bp%0d busy", k), busy, 1'b1);
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        chk("bp release busy", busy, 1'b0);
        chk("bp release rsp_valid", rsp_valid, 2'b00);
        chk("bp tie after p1", req_ready, 2'b01);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);

        // Reset during EXEC drops the transaction.
        req_valid = 2'b01;
        req_a0 = 64'd5; req_b0 = 64'd6; req_op0 = 2'b10;
        #1;
        chk("rst-mid accept", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("rst-mid exec busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst-mid busy", busy, 1'b0);
        chk("rst-mid rsp_valid", rsp_valid, 2'b00);
        chk("rst-mid rsp_data", rsp_data, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst-mid no rsp %0d", k), rsp_valid, 2'b00);
        end
        req_valid = 2'b11;
        #1;
        chk("rst-mid tie to port0", req_ready, 2'b01);
        req_valid = 2'b00;
        @(negedge clk);

        // Back-to-back on port 1; operands change right after each accept.
        req_valid = 2'b10;
        rsp_ready = 2'b11;
        req_a1 = b2b_a[0]; req_b1 = b2b_b[0]; req_op1 = b2b_op[0];
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("b2b%0d accept", k), req_ready, 2'b10);
            @(posedge clk);
            #1;
            if (k < 2) begin
                req_a1 = b2b_a[k+1]; req_b1 = b2b_b[k+1]; req_op1 = b2b_op[k+1];
            end else begin
                req_valid = 2'b00;
            end
            @(negedge clk);
            chk($sformatf("b2b%0d exec ready", k), req_ready, 2'b00);
            @(negedge clk);
            chk($sformatf("b2b%0d rsp_valid", k), rsp_valid, 2'b10);
            chk($sformatf("b2b%0d rsp_data", k), rsp_data, b2b_exp[k]);
            chk($sformatf("b2b%0d resp ready", k), req_ready, 2'b00);
            @(negedge clk);
        end
        chk("b2b final busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
